// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock/run controller.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_STEP    = 2'b01,
    MODE_HALT    = 2'b10,
    MODE_RUN_BRK = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_STEP    = 3'd1,
    ST_HALT    = 3'd2,
    ST_RUN_BRK = 3'd3,
    ST_BREAK   = 3'd4
  } state_e;

  // 10 ms of stable key level at 50 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/key_debounce.sv
// Step-key conditioning: 2-flop synchroniser, debounce counter and a
// one-cycle pulse on each accepted press (accepted level falling 1->0).
module key_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short bounces are discarded.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Board-level CPU clock-enable and run-mode controller: reset synchroniser,
// programmable divider, run/step/halt/breakpoint FSM and enable counter.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_mode,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_step_key_n,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_brk_pc,
  output logic                 o_cpu_rst_n,
  output logic                 o_cpu_en,
  output logic                 o_halted,
  output logic                 o_brk_hit,
  output logic [CNT_WIDTH-1:0] o_en_cnt
);

  logic [1:0]           rst_sync_q;
  logic                 cpu_rst_n;
  logic                 press;
  logic                 tick;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic                 brk_hit_q, brk_hit_d;
  logic                 mask_q, mask_d;
  logic [CNT_WIDTH-1:0] en_cnt_q, en_cnt_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_debounce (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_n_i (i_step_key_n),
    .press_o (press)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign cpu_rst_n = rst_sync_q[1];

  // ">=" rather than "==" so lowering i_div below the count ticks at once.
  always_comb begin
    tick      = cpu_rst_n && (div_cnt_q >= i_div);
    div_cnt_d = (!cpu_rst_n || tick) ? '0 : div_cnt_q + DIV_WIDTH'(1);
  end

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    brk_hit_d = 1'b0;
    mask_d    = 1'b0;
    if (!cpu_rst_n) begin
      state_d = ST_HALT;
    end else begin
      case (mode_e'(i_mode))
        MODE_RUN: begin
          state_d = ST_RUN;
          en_d    = tick;
        end
        MODE_STEP: begin
          state_d = ST_STEP;
          en_d    = press;
        end
        MODE_HALT: state_d = ST_HALT;
        MODE_RUN_BRK: begin
          brk_hit_d = brk_hit_q;
          mask_d    = mask_q;
          // The mask lets a one-instruction loop at the break PC be stepped.
          if (state_q == ST_BREAK) begin
            if (press) begin
              en_d    = 1'b1;
              state_d = ST_RUN_BRK;
              mask_d  = 1'b1;
            end
          end else begin
            state_d = ST_RUN_BRK;
            if (tick) begin
              mask_d = 1'b0;
              if (!mask_q && (i_pc == i_brk_pc)) begin
                state_d   = ST_BREAK;
                brk_hit_d = 1'b1;
              end else begin
                en_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_comb begin
    en_cnt_d = en_cnt_q;
    if (!cpu_rst_n)  en_cnt_d = '0;
    else if (en_q)   en_cnt_d = en_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_q <= '0;
      state_q   <= ST_HALT;
      en_q      <= 1'b0;
      brk_hit_q <= 1'b0;
      mask_q    <= 1'b0;
      en_cnt_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      en_q      <= en_d;
      brk_hit_q <= brk_hit_d;
      mask_q    <= mask_d;
      en_cnt_q  <= en_cnt_d;
    end
  end

  assign o_cpu_rst_n = cpu_rst_n;
  assign o_cpu_en    = en_q;
  assign o_halted    = state_q inside {ST_HALT, ST_BREAK, ST_STEP};
  assign o_brk_hit   = brk_hit_q;
  assign o_en_cnt    = en_cnt_q;

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Board-level clock/run controller for the single-cycle core, replacing the fixed divide-by-2 clock divider.
- Generates a one-cycle CPU clock enable from the 50 MHz board clock, with a runtime-programmable divide ratio.
- Adds run, single-step, halt and run-to-breakpoint modes driven by SW/KEY, plus a synchronised reset release and an enable counter.
- Sits between the board pins and the core; the core runs on i_clk gated by o_cpu_en (no derived clocks).

Parameters:
- DIV_WIDTH, 24: width of the divide-ratio input and the divider counter.
- DB_CYCLES, 500000: consecutive stable samples required to accept a key level (10 ms at 50 MHz).
- CNT_WIDTH, 32: width of the enable counter.

Ports:
- i_clk  input  1  board clock (50 MHz).
- i_rst_n  input  1  asynchronous active-low reset.
- i_mode  input  2  00 RUN, 01 STEP, 10 HALT, 11 RUN_BRK.
- i_div  input  DIV_WIDTH  enable period minus 1 (0 = enable every cycle).
- i_step_key_n  input  1  raw, asynchronous, active-low push button.
- i_pc  input  32  current core PC.
- i_brk_pc  input  32  breakpoint address.
- o_cpu_rst_n  output  1  synchronised core reset.
- o_cpu_en  output  1  one-cycle CPU clock enable.
- o_halted  output  1  high when no enables are being issued (HALT, STEP idle, BREAK).
- o_brk_hit  output  1  sticky breakpoint-hit flag.
- o_en_cnt  output  CNT_WIDTH  number of enables issued; wraps.

Behaviour:
- Clocking and reset:
  - Single clock i_clk; reset i_rst_n is asynchronous and active-low, as decided.
  - All flops are cleared asynchronously on reset.
  - Reset values: o_cpu_rst_n=0, o_cpu_en=0, o_halted=1, o_brk_hit=0, o_en_cnt=0, FSM=HALT, divider=0.
- Reset synchroniser:
  - o_cpu_rst_n asserts asynchronously with i_rst_n.
  - It deasserts on the 2nd rising edge after i_rst_n rises (2-flop synchroniser).
  - While o_cpu_rst_n=0: o_cpu_en=0, divider and o_en_cnt held at 0.
- Step key path:
  - 2-flop synchroniser, then debounce: the accepted level changes only after DB_CYCLES consecutive equal samples.
  - A press event is a one-cycle pulse on the accepted 1->0 transition; release generates nothing.
  - Bounces shorter than DB_CYCLES produce no event.
- Divider:
  - Counter increments each cycle; tick=1 when cnt >= i_div, and cnt returns to 0 on that cycle.
  - If i_div is lowered below cnt mid-count, the next cycle ticks; there is no long wrap.
  - The divider free-runs in all modes.
- FSM (states RUN, STEP, HALT, RUN_BRK, BREAK):
  - Mode decode is evaluated every cycle and overrides the state, except RUN_BRK->BREAK, which is held until a step press or a mode change.
  - RUN: o_cpu_en=tick.
  - STEP: o_cpu_en=press event; exactly one enable per press, independent of the divider.
  - HALT: o_cpu_en=0; press events are ignored.
  - RUN_BRK: on a tick, if i_pc==i_brk_pc, issue no enable, set o_brk_hit, go to BREAK. The instruction at the break PC is not executed.
  - BREAK: o_cpu_en=0. A press event issues one enable and returns to RUN_BRK, with the break compare masked for the next tick only so a one-instruction loop can still be stepped.
  - Mode change out of BREAK goes directly to the new mode.
- o_brk_hit: set on a break match; cleared when i_mode != RUN_BRK or on reset.
- o_cpu_en is registered: one cycle of latency from tick/press to the enable.
- o_en_cnt increments on every o_cpu_en=1 cycle and wraps 2^CNT_WIDTH-1 -> 0.
- o_halted = (state in {HALT, BREAK}) or (state==STEP).
- Simultaneous events:
  - Tick and mode change in the same cycle: the new mode governs that cycle's decision.
  - Reset mid-step: the pending enable is discarded.

Decomposition:
- Package cpu_clk_ctrl_pkg: mode_e (RUN, STEP, HALT, RUN_BRK encodings), state_e, default DB_CYCLES constant.
- Sub-module key_debounce (synchroniser + debounce counter + press pulse), parametrised by DB_CYCLES.
- cpu_clk_ctrl instantiates key_debounce and contains the reset synchroniser, divider and FSM.

Test Plan:
- Reset release: i_rst_n 0->1 -> o_cpu_rst_n rises exactly 2 edges later; all outputs hold reset values until then.
- RUN, i_div=3, DB_CYCLES=4 -> o_cpu_en high 1 of every 4 cycles; o_en_cnt=10 after 40 cycles.
- RUN with i_div changed from 9 to 2 while cnt=7 -> tick on the next cycle, then period 3.
- STEP: key bounce of 2 cycles is ignored; stable low for 4+ cycles -> exactly one o_cpu_en pulse; held key gives no further pulses.
- RUN_BRK, i_brk_pc=0x0000_0010, PC advancing by 4 -> enables stop with i_pc=0x10, o_brk_hit=1, o_halted=1; one press -> one enable, PC reaches 0x14, run resumes.
- o_en_cnt preloaded via run to 2^CNT_WIDTH-1 (CNT_WIDTH=4 build) -> next enable gives 0; reset asserted mid-RUN clears o_cpu_en immediately.
